rotating_square_gen: RTL



---
 rtl/rotating_square_gen.sv | 60 ++++++
 1 files changed

// File: rtl/rotating_square_gen.sv
// Rotating-square animation for a 4-digit active-low seven-segment display.
// A prescaler paces a 3-bit position that walks the upper and lower squares in either direction.
module rotating_square_gen #(
   parameter int TICK_MAX = 24_999_999,
   parameter int TICK_W   = 25
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       cw,
   output logic [3:0] an,
   output logic [7:0] sseg,
   output logic [2:0] pos,
   output logic       tick
);

   localparam logic [TICK_W-1:0] LP_TICK_MAX = TICK_W'(TICK_MAX);
   localparam logic [7:0]        LP_UPPER    = 8'h9C;
   localparam logic [7:0]        LP_LOWER    = 8'hA3;

   logic [TICK_W-1:0] r_cnt;
   logic [2:0]        r_pos;
   logic              w_tick;
   logic [3:0]        w_an;
   logic [7:0]        w_sseg;

   assign w_tick = en && (r_cnt == LP_TICK_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_pos <= '0;
      end else if (en) begin
         r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         // Direction is only looked at on the step edge, so cw changes between steps are invisible.
         if (w_tick) begin
            r_pos <= cw ? r_pos + 3'd1 : r_pos - 3'd1;
         end
      end
   end

   // Positions 0-3 sweep the top row left to right, 4-7 sweep the bottom row back.
   always_comb begin
      w_an = 4'b0111;
      unique case (r_pos)
         3'd0, 3'd7: w_an = 4'b0111;
         3'd1, 3'd6: w_an = 4'b1011;
         3'd2, 3'd5: w_an = 4'b1101;
         3'd3, 3'd4: w_an = 4'b1110;
         default:    w_an = 4'b0111;
      endcase
      w_sseg = r_pos[2] ? LP_LOWER : LP_UPPER;
   end

   assign an   = w_an;
   assign sseg = w_sseg;
   assign pos  = r_pos;
   assign tick = w_tick;

endmodule
